ahb_slave_arbiter: RTL and testbench

- Sequential per-slave arbiter that sits beside the master-to-slave mux on each AHB slave port.
- Consumes per-master address-decode requests and the muxed transfer controls (htrans/hburst/hready).
- Produces a registered one-hot grant that selects the mux input.
- Uses round-robin fairness and keeps ownership for the full length of fixed-length bursts, with a bounded hold for INCR bursts.

---
 rtl/ahb_slave_arbiter_if.sv | 27 ++
 rtl/ahb_slave_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_ahb_slave_arbiter.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_slave_arbiter_if.sv
// Bus bundle between one AHB slave port mux and its arbiter.
// The arbiter connects through the slave modport; the master modport drives requests and transfer controls.
interface ahb_slave_arbiter_if #(
    parameter int HMAS_NUM     = 5,
    parameter int HBURST_WIDTH = 3
);
    localparam int IDX_W = (HMAS_NUM > 1) ? $clog2(HMAS_NUM) : 1;

    logic [HMAS_NUM-1:0]     req_m;
    logic [1:0]              htrans_s;
    logic [HBURST_WIDTH-1:0] hburst_s;
    logic                    hready_s;
    logic [HMAS_NUM-1:0]     grant;
    logic [IDX_W-1:0]        hmaster;
    logic                    hsel_s;
    logic [7:0]              beat_cnt;

    modport slave (
        input  req_m, htrans_s, hburst_s, hready_s,
        output grant, hmaster, hsel_s, beat_cnt
    );

    modport master (
        output req_m, htrans_s, hburst_s, hready_s,
        input  grant, hmaster, hsel_s, beat_cnt
    );
endinterface

// File: rtl/ahb_slave_arbiter.sv
// Per-slave round-robin arbiter with a registered one-hot grant.
// Fixed-length bursts keep ownership to the end; INCR bursts can be preempted after INCR_MAX_BEATS.
module ahb_slave_arbiter #(
    parameter int HMAS_NUM       = 5,
    parameter int HBURST_WIDTH   = 3,
    parameter int INCR_MAX_BEATS = 16
) (
    input  logic                  hclk,
    input  logic                  hreset,
    ahb_slave_arbiter_if.slave    bus
);
    localparam int IDX_W = (HMAS_NUM > 1) ? $clog2(HMAS_NUM) : 1;
    localparam logic [7:0] INCR_MAX_B = 8'(INCR_MAX_BEATS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANTED = 2'd1,
        ST_FIXED   = 2'd2,
        ST_INCR    = 2'd3
    } state_t;

    state_t                 state_r;
    state_t                 nxt_state_s;
    logic [HMAS_NUM-1:0]    grant_r;
    logic [IDX_W-1:0]       hmaster_r;
    logic                   hsel_r;
    logic [7:0]             beat_cnt_r;
    logic [7:0]             burst_len_r;
    logic [IDX_W-1:0]       rr_ptr_r;

    logic                   pick_valid_s;
    logic [IDX_W-1:0]       pick_idx_s;
    logic [IDX_W-1:0]       rr_next_s;
    logic [HMAS_NUM-1:0]    pick_onehot_s;
    logic                   beat_ok_s;
    logic                   is_idle_s;
    logic                   is_seq_s;
    logic                   is_nonseq_s;
    logic                   owner_req_s;
    logic                   others_req_s;
    logic [7:0]             new_len_s;
    logic [7:0]             cnt_inc_s;
    logic                   take_pick_s;
    logic                   restart_s;
    logic [7:0]             nxt_cnt_s;
    logic [7:0]             nxt_len_s;

    // Burst length in beats; 0 stands for an unbounded INCR burst.
    function automatic logic [7:0] burst_len_f(input logic [HBURST_WIDTH-1:0] hb);
        logic [7:0] len;
        case (hb)
            HBURST_WIDTH'(0): len = 8'd1;
            HBURST_WIDTH'(1): len = 8'd0;
            HBURST_WIDTH'(2), HBURST_WIDTH'(3): len = 8'd4;
            HBURST_WIDTH'(4), HBURST_WIDTH'(5): len = 8'd8;
            HBURST_WIDTH'(6), HBURST_WIDTH'(7): len = 8'd16;
            default: len = 8'd1;
        endcase
        return len;
    endfunction

    function automatic logic [IDX_W-1:0] wrap_idx_f(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        return (sum >= HMAS_NUM) ? IDX_W'(sum - HMAS_NUM) : IDX_W'(sum);
    endfunction

    assign beat_ok_s     = hsel_r & bus.hready_s & bus.htrans_s[1];
    assign is_idle_s     = (bus.htrans_s == 2'd0);
    assign is_nonseq_s   = (bus.htrans_s == 2'd2);
    assign is_seq_s      = (bus.htrans_s == 2'd3);
    assign owner_req_s   = |(bus.req_m & grant_r);
    assign others_req_s  = |(bus.req_m & ~grant_r);
    assign new_len_s     = burst_len_f(bus.hburst_s);
    assign cnt_inc_s     = (beat_cnt_r == 8'd255) ? 8'd255 : (beat_cnt_r + 8'd1);
    assign rr_next_s     = wrap_idx_f(pick_idx_s, 1);
    assign pick_onehot_s = {{(HMAS_NUM-1){1'b0}}, 1'b1} << pick_idx_s;

    // Round-robin search: scanning from the far end lets the nearest requester to rr_ptr win.
    always_comb begin
        pick_valid_s = |bus.req_m;
        pick_idx_s   = '0;
        for (int k = HMAS_NUM - 1; k >= 0; k--) begin
            pick_idx_s = bus.req_m[wrap_idx_f(rr_ptr_r, k)] ? wrap_idx_f(rr_ptr_r, k) : pick_idx_s;
        end
    end

    // Burst tracking and the decision to re-arbitrate at this edge.
    always_comb begin
        take_pick_s = 1'b0;
        restart_s   = 1'b0;
        nxt_state_s = state_r;
        nxt_cnt_s   = beat_cnt_r;
        nxt_len_s   = burst_len_r;
        case (state_r)
            ST_IDLE: take_pick_s = 1'b1;
            ST_GRANTED: begin
                if (beat_ok_s && is_nonseq_s) begin
                    restart_s = 1'b1;
                end else if (is_idle_s && !owner_req_s) begin
                    take_pick_s = 1'b1;
                end else begin
                    nxt_state_s = ST_GRANTED;
                end
            end
            ST_FIXED: begin
                if (beat_ok_s && is_nonseq_s) begin
                    restart_s = 1'b1;
                end else if (beat_ok_s && is_seq_s) begin
                    nxt_cnt_s = cnt_inc_s;
                    if (cnt_inc_s >= burst_len_r) begin
                        take_pick_s = 1'b1;
                    end else begin
                        nxt_state_s = ST_FIXED;
                    end
                end else if (is_idle_s) begin
                    take_pick_s = 1'b1;
                end else begin
                    nxt_state_s = ST_FIXED;
                end
            end
            ST_INCR: begin
                if (is_idle_s || !owner_req_s) begin
                    take_pick_s = 1'b1;
                end else if (beat_ok_s && is_nonseq_s) begin
                    restart_s = 1'b1;
                end else begin
                    if (beat_ok_s && is_seq_s) begin
                        nxt_cnt_s = cnt_inc_s;
                    end else begin
                        nxt_cnt_s = beat_cnt_r;
                    end
                    // Preemption counts the beat accepted at this very edge.
                    if ((nxt_cnt_s >= INCR_MAX_B) && others_req_s) begin
                        take_pick_s = 1'b1;
                    end else begin
                        nxt_state_s = ST_INCR;
                    end
                end
            end
            default: take_pick_s = 1'b1;
        endcase
        if (restart_s) begin
            nxt_cnt_s = 8'd1;
            nxt_len_s = new_len_s;
            if (new_len_s == 8'd1) begin
                take_pick_s = 1'b1;
            end else if (new_len_s == 8'd0) begin
                nxt_state_s = ST_INCR;
            end else begin
                nxt_state_s = ST_FIXED;
            end
        end else begin
            nxt_len_s = burst_len_r;
        end
    end

    // Arbiter state and registered grant outputs; a wait state freezes everything.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_r     <= ST_IDLE;
            grant_r     <= '0;
            hmaster_r   <= '0;
            hsel_r      <= 1'b0;
            beat_cnt_r  <= 8'd0;
            burst_len_r <= 8'd0;
            rr_ptr_r    <= '0;
        end else if (bus.hready_s) begin
            if (take_pick_s) begin
                beat_cnt_r  <= 8'd0;
                burst_len_r <= 8'd0;
                if (pick_valid_s) begin
                    state_r   <= ST_GRANTED;
                    grant_r   <= pick_onehot_s;
                    hmaster_r <= pick_idx_s;
                    hsel_r    <= 1'b1;
                    rr_ptr_r  <= rr_next_s;
                end else begin
                    state_r   <= ST_IDLE;
                    grant_r   <= '0;
                    hmaster_r <= '0;
                    hsel_r    <= 1'b0;
                end
            end else begin
                state_r     <= nxt_state_s;
                beat_cnt_r  <= nxt_cnt_s;
                burst_len_r <= nxt_len_s;
            end
        end
    end

    assign bus.grant    = grant_r;
    assign bus.hmaster  = hmaster_r;
    assign bus.hsel_s   = hsel_r;
    assign bus.beat_cnt = beat_cnt_r;
endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Randomized plus directed bench for ahb_slave_arbiter against a transaction-level ownership model.
module tb_ahb_slave_arbiter;
    localparam int N    = 5;
    localparam int MAXB = 16;
    localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NONSEQ = 2'd2, T_SEQ = 2'd3;

    typedef struct {
        int owner;   // -1 when nobody owns the slave
        int rr;
        int cnt;
        int len;     // 0 for INCR
        bit burst;
        bit incr;
    } mstate_t;

    logic    hclk;
    logic    hreset;
    int      n_checks = 0;
    int      n_errors = 0;
    bit      chk_en   = 1'b0;
    mstate_t m        = '{owner: -1, rr: 0, cnt: 0, len: 0, burst: 1'b0, incr: 1'b0};

    ahb_slave_arbiter_if #(.HMAS_NUM(N), .HBURST_WIDTH(3)) bus ();

    ahb_slave_arbiter #(.HMAS_NUM(N), .HBURST_WIDTH(3), .INCR_MAX_BEATS(MAXB)) dut (
        .hclk   (hclk),
        .hreset (hreset),
        .bus    (bus)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    function automatic int blen(input logic [2:0] hb);
        if (hb == 3'd0) return 1;
        if (hb == 3'd1) return 0;
        return 1 << ((int'(hb) >> 1) + 1);
    endfunction

    // Ownership rules at one clock edge, phrased per transfer rather than per RTL state.
    function automatic mstate_t model_step(input mstate_t s, input bit rst, input logic [4:0] req,
                                           input logic [1:0] tr, input logic [2:0] hb, input bit rdy);
        mstate_t n;
        bit rel;
        bit start;
        bit found;
        bit oreq;
        int l;
        n = s;
        rel = 1'b0;
        start = 1'b0;
        if (rst) begin
            n = '{owner: -1, rr: 0, cnt: 0, len: 0, burst: 1'b0, incr: 1'b0};
            return n;
        end
        if (!rdy) return n;
        if (s.owner < 0) begin
            rel = 1'b1;
        end else begin
            oreq = req[s.owner];
            if (!s.burst) begin
                if (tr == T_NONSEQ) start = 1'b1;
                else if (tr == T_IDLE && !oreq) rel = 1'b1;
            end else if (!s.incr) begin
                if (tr == T_NONSEQ) start = 1'b1;
                else if (tr == T_SEQ) begin
                    n.cnt = s.cnt + 1;
                    if (n.cnt >= s.len) rel = 1'b1;
                end else if (tr == T_IDLE) rel = 1'b1;
            end else begin
                if (tr == T_IDLE || !oreq) rel = 1'b1;
                else if (tr == T_NONSEQ) start = 1'b1;
                else begin
                    if (tr == T_SEQ) n.cnt = (s.cnt + 1 > 255) ? 255 : s.cnt + 1;
                    if (n.cnt >= MAXB && (int'(req) & ~(1 << s.owner)) != 0) rel = 1'b1;
                end
            end
        end
        if (start) begin
            n.cnt = 1;
            l = blen(hb);
            if (l == 1) rel = 1'b1;
            else begin
                n.burst = 1'b1;
                n.incr = (l == 0);
                n.len = l;
            end
        end
        if (rel) begin
            n.cnt = 0;
            n.len = 0;
            n.burst = 1'b0;
            n.incr = 1'b0;
            n.owner = -1;
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!found && req[(s.rr + k) % N]) begin
                    found = 1'b1;
                    n.owner = (s.rr + k) % N;
                    n.rr = ((s.rr + k) % N + 1) % N;
                end
            end
        end
        return n;
    endfunction

    always @(posedge hclk) begin
        m <= model_step(m, hreset, bus.req_m, bus.htrans_s, bus.hburst_s, bus.hready_s);
    end

    function automatic logic [4:0] model_grant();
        return (m.owner < 0) ? 5'd0 : 5'(1 << m.owner);
    endfunction

    // Every-cycle comparison of all outputs against the model.
    always @(negedge hclk) begin
        logic [4:0] eg;
        logic [2:0] eh;
        logic [7:0] eb;
        if (chk_en) begin
            eg = model_grant();
            eh = (m.owner < 0) ? 3'd0 : 3'(m.owner);
            eb = 8'(m.cnt);
            n_checks++;
            if (bus.grant !== eg || bus.hmaster !== eh || bus.hsel_s !== (|eg) || bus.beat_cnt !== eb) begin
                n_errors++;
                $display("FAIL cycle_cmp t=%0t grant=%b exp=%b hmaster=%0d exp=%0d hsel=%b exp=%b beat_cnt=%0d exp=%0d",
                         $time, bus.grant, eg, bus.hmaster, eh, bus.hsel_s, |eg, bus.beat_cnt, eb);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pin(input string name, input logic [4:0] g, input logic [7:0] bc);
        int hm;
        hm = 0;
        for (int i = 0; i < N; i++) if (g[i]) hm = i;
        check({name, "_grant"}, 32'(bus.grant), 32'(g));
        check({name, "_model"}, 32'(model_grant()), 32'(g));
        check({name, "_hmaster"}, 32'(bus.hmaster), 32'(hm));
        check({name, "_hsel"}, 32'(bus.hsel_s), 32'(|g));
        check({name, "_beat"}, 32'(bus.beat_cnt), 32'(bc));
    endtask

    task automatic cyc(input logic [4:0] r, input logic [1:0] t, input logic [2:0] b, input logic rdy);
        bus.req_m    = r;
        bus.htrans_s = t;
        bus.hburst_s = b;
        bus.hready_s = rdy;
        @(posedge hclk);
        #1;
    endtask

    task automatic do_reset();
        hreset = 1'b1;
        cyc(5'b00000, T_IDLE, 3'd0, 1'b1);
        hreset = 1'b0;
    endtask

    initial begin
        logic [4:0] r;
        logic [1:0] t;
        logic [2:0] b;
        logic       rdy;
        int         pr;

        hreset = 1'b1;
        cyc(5'b00000, T_IDLE, 3'd0, 1'b1);
        hreset = 1'b0;
        chk_en = 1'b1;
        pin("reset", 5'b00000, 8'd0);

        // Single owner, one SINGLE transfer, request dropped.
        cyc(5'b00100, T_IDLE, 3'd0, 1'b1);
        pin("first_grant", 5'b00100, 8'd0);
        cyc(5'b00000, T_NONSEQ, 3'd0, 1'b1);
        pin("single_release", 5'b00000, 8'd0);

        // Strict round robin with everybody requesting.
        do_reset();
        cyc(5'b11111, T_IDLE, 3'd0, 1'b1);
        pin("rr0", 5'b00001, 8'd0);
        for (int i = 1; i <= 5; i++) begin
            cyc(5'b11111, T_NONSEQ, 3'd0, 1'b1);
            pin($sformatf("rr%0d", i), 5'(1 << (i % 5)), 8'd0);
        end

        // INCR8 from master 0 with wait states, master 3 waiting.
        do_reset();
        cyc(5'b00001, T_IDLE, 3'd0, 1'b1);
        cyc(5'b01001, T_NONSEQ, 3'd5, 1'b1);
        pin("incr8_b1", 5'b00001, 8'd1);
        cyc(5'b01001, T_SEQ, 3'd5, 1'b1);
        cyc(5'b01001, T_SEQ, 3'd5, 1'b1);
        for (int i = 0; i < 2; i++) begin
            cyc(5'b01001, T_SEQ, 3'd5, 1'b0);
            pin("incr8_wait", 5'b00001, 8'd3);
        end
        cyc(5'b01001, T_SEQ, 3'd5, 1'b1);
        pin("incr8_b4", 5'b00001, 8'd4);
        for (int i = 5; i <= 7; i++) cyc(5'b01001, T_SEQ, 3'd5, 1'b1);
        pin("incr8_b7", 5'b00001, 8'd7);
        cyc(5'b01001, T_SEQ, 3'd5, 1'b1);
        pin("incr8_handover", 5'b01000, 8'd0);

        // INCR preemption after 16 beats.
        do_reset();
        cyc(5'b00010, T_IDLE, 3'd0, 1'b1);
        cyc(5'b00010, T_NONSEQ, 3'd1, 1'b1);
        cyc(5'b00010, T_SEQ, 3'd1, 1'b1);
        for (int i = 3; i <= 15; i++) cyc(5'b10010, T_SEQ, 3'd1, 1'b1);
        pin("incr_b15", 5'b00010, 8'd15);
        cyc(5'b10010, T_SEQ, 3'd1, 1'b1);
        pin("incr_preempt", 5'b10000, 8'd0);

        // INCR without competition runs past the limit.
        do_reset();
        cyc(5'b00010, T_IDLE, 3'd0, 1'b1);
        cyc(5'b00010, T_NONSEQ, 3'd1, 1'b1);
        for (int i = 2; i <= 20; i++) cyc(5'b00010, T_SEQ, 3'd1, 1'b1);
        pin("incr_b20", 5'b00010, 8'd20);

        // WRAP4 cut short by IDLE.
        do_reset();
        cyc(5'b00100, T_IDLE, 3'd0, 1'b1);
        cyc(5'b00101, T_NONSEQ, 3'd2, 1'b1);
        cyc(5'b00101, T_SEQ, 3'd2, 1'b1);
        pin("wrap4_b2", 5'b00100, 8'd2);
        cyc(5'b00101, T_IDLE, 3'd2, 1'b1);
        pin("wrap4_early", 5'b00001, 8'd0);

        // Reset in the middle of an INCR16.
        do_reset();
        cyc(5'b00001, T_IDLE, 3'd0, 1'b1);
        cyc(5'b00001, T_NONSEQ, 3'd7, 1'b1);
        cyc(5'b00001, T_SEQ, 3'd7, 1'b1);
        hreset = 1'b1;
        cyc(5'b00001, T_SEQ, 3'd7, 1'b1);
        hreset = 1'b0;
        pin("midreset", 5'b00000, 8'd0);
        cyc(5'b00010, T_IDLE, 3'd0, 1'b1);
        pin("after_reset", 5'b00010, 8'd0);
        // rr_ptr must restart at 0: master 0 beats master 4 although master 0 owned before reset.
        do_reset();
        cyc(5'b00001, T_IDLE, 3'd0, 1'b1);
        hreset = 1'b1;
        cyc(5'b00001, T_IDLE, 3'd0, 1'b1);
        hreset = 1'b0;
        cyc(5'b10001, T_IDLE, 3'd0, 1'b1);
        pin("rr_restart", 5'b00001, 8'd0);

        // Random traffic driven as the current owner would, checked every cycle.
        do_reset();
        r = 5'b00000;
        b = 3'd0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (m.owner == i) begin
                    if ($urandom_range(99) < 3) r[i] = ~r[i];
                end else if ($urandom_range(99) < 12) begin
                    r[i] = ~r[i];
                end
            end
            pr = int'($urandom_range(99));
            if (m.owner < 0) t = 2'($urandom_range(3));
            else if (!m.burst) t = (pr < 70) ? T_NONSEQ : (pr < 88) ? T_IDLE : (pr < 94) ? T_BUSY : T_SEQ;
            else t = (pr < 84) ? T_SEQ : (pr < 91) ? T_BUSY : (pr < 96) ? T_NONSEQ : T_IDLE;
            if (t == T_NONSEQ) b = ($urandom_range(99) < 35) ? 3'd1 : 3'($urandom_range(7));
            rdy = ($urandom_range(99) < 85);
            hreset = ($urandom_range(999) < 3);
            cyc(r, t, b, rdy);
        end
        hreset = 1'b0;
        cyc(5'b00000, T_IDLE, 3'd0, 1'b1);

        @(negedge hclk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
